mips_decode_stage: RTL and testbench
====================================

Name: mips_decode_stage

Overview:
- Parametrised, pipelined MIPS instruction-decode stage sitting between instruction fetch and the execute/register-file stage.
- Decodes an extended opcode/funct set into control signals, a width-extended immediate and a destination register.
- Uses valid/ready handshakes on both sides, with a 2-entry skid buffer so out_ready is never combinationally tied to in_ready.
- Supports flush and keeps a saturating illegal-instruction counter.

Parameters:
- XLEN, 32: PC and immediate width; must be >= 32.
- EN_EXT, 1: 1 enables the extended set (ANDI, ORI, SLTI, BNE, LUI, JAL, NOR, SLL, SRL); 0 decodes the base set only, and extended encodings are illegal.
- CNT_W, 16: width of the illegal-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  discard all held entries
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_ins  in  32  instruction word
- in_pc  in  XLEN  PC of instruction
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  PC passed through
- out_rs, out_rt  out  5 each  source register fields
- out_wreg  out  5  write register: rd (R-type), rt (I-type), 31 (JAL)
- out_imm  out  XLEN  extended immediate
- out_shamt  out  5  shift amount
- out_jaddr  out  26  jump word address
- RegWrite, MemtoReg, MemWrite, ALUSrc, Branch, BranchNe, Jump, Link  out  1 each  control
- alu_control  out  4  ALU operation
- illegal  out  1  entry is an undecodable instruction
- ill_cnt  out  CNT_W  saturating count of illegal instructions delivered

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, every control output=0, alu_control=0, all payload fields=0, ill_cnt=0.
  - in_ready=1 from the first cycle after release.
- Opcodes:
  - R=000000, LW=100011, SW=101011, BEQ=000100, BNE=000101, J=000010, JAL=000011, ADDI=001000, SLTI=001010, ANDI=001100, ORI=001101, LUI=001111.
- ALU codes:
  - AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100, SLL=1000, SRL=1001, FALSE=1111.
- R-type decode:
  - funct 100100/100101/100000/100010/101010/100111/000000/000010 maps to AND/OR/ADD/SUB/SLT/NOR/SLL/SRL.
  - Any other funct is illegal.
- Control per opcode:
  - BEQ/BNE: alu_control=SUB.
  - SLTI: SLT. ANDI: AND. ORI: OR.
  - LW, SW, ADDI, LUI, J, JAL: ADD.
  - ALUSrc=1 for LW, SW, ADDI, SLTI, ANDI, ORI, LUI.
  - RegWrite=1 for R, LW, ADDI, SLTI, ANDI, ORI, LUI, JAL.
  - Jump=1 for J and JAL. Link=1 for JAL only. BranchNe=1 for BNE only.
- Immediate:
  - Sign-extended from bit 15 to XLEN bits by default.
  - Zero-extended for ANDI and ORI.
  - LUI: {ins[15:0], 16'h0}, then zero-extended to XLEN.
- Illegal entries:
  - Unknown opcode, unknown funct, or an extended encoding with EN_EXT=0.
  - Set illegal=1, force RegWrite=MemWrite=Branch=BranchNe=Jump=Link=0, alu_control=FALSE.
- Latency: decode is registered; an instruction accepted in cycle N appears on out_* in cycle N+1 at the earliest.
- Buffer states, with in_ready = (state != FULL), driven from a register:
  - EMPTY: accept → ONE.
  - ONE: output handshake without accept → EMPTY. Handshake with accept → ONE, new entry on output. Accept without handshake → FULL, new entry goes to skid.
  - FULL: output handshake → ONE, skid moves to output the next cycle. No input is accepted in FULL.
- Output stability: while out_valid=1 and out_ready=0, all out_* and control outputs are held stable.
- Flush: next state is EMPTY, out_valid=0, control outputs=0. An input presented in the flush cycle is dropped. An output handshake in the flush cycle still counts as delivered.
- ill_cnt:
  - Increments on an output handshake when illegal=1.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; not affected by flush.

Test Plan:
- Reset, then in_ins=0x00221820 (add $3,$1,$2) with out_ready=1 → next cycle out_valid=1, RegWrite=1, alu_control=0010, out_wreg=3, illegal=0.
- ANDI 0x3042FFFF → out_imm=0x0000FFFF, alu_control=0000, ALUSrc=1. Then ADDI 0x2042FFFF → out_imm=0xFFFFFFFF, alu_control=0010.
- JAL 0x0C000010 → Jump=1, Link=1, RegWrite=1, out_wreg=31, out_jaddr=0x10. Repeat with EN_EXT=0 → illegal=1, all write enables 0, alu_control=1111.
- Back-to-back stream of 4 instructions with out_ready held 0 for 3 cycles → in_ready drops after 2 accepts; order preserved; no loss or duplication; outputs stable while stalled.
- Stage FULL, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, dropped entry never appears. Deassert rst_n mid-stream → outputs zero immediately.
- Deliver 3 instructions 0xFC000000 (illegal) with CNT_W=2 → ill_cnt sequence 1, 2, 3, 3 after a fourth.

Source files
------------

// File: rtl/mips_decode_stage.sv
// MIPS instruction-decode stage: registered decode into a 2-entry output/skid buffer
// with valid/ready handshakes on both sides, flush, and a saturating illegal counter.
module mips_decode_stage #(
    parameter int XLEN   = 32,
    parameter int EN_EXT = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ins,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_wreg,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_shamt,
    output logic [25:0]      out_jaddr,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             MemWrite,
    output logic             ALUSrc,
    output logic             Branch,
    output logic             BranchNe,
    output logic             Jump,
    output logic             Link,
    output logic [3:0]       alu_control,
    output logic             illegal,
    output logic [CNT_W-1:0] ill_cnt
);
    // Handshake: a transfer happens on a rising edge where valid && ready on that side;
    // valid never waits on ready, and in_ready comes straight from a flop.

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;
    localparam logic [3:0] ALU_FALSE = 4'b1111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      wreg;
        logic [4:0]      shamt;
        logic [XLEN-1:0] imm;
        logic [25:0]     jaddr;
        logic            reg_write;
        logic            mem_to_reg;
        logic            mem_write;
        logic            alu_src;
        logic            branch;
        logic            branch_ne;
        logic            jump;
        logic            link;
        logic [3:0]      alu;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    state_t             state_q, state_d;
    entry_t             out_q, out_d;
    entry_t             skid_q, skid_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   ill_cnt_q, ill_cnt_d;

    entry_t dec;
    logic   legal;
    logic   ext;
    logic   accept;
    logic   hs;

    always_comb begin
        dec        = '0;
        legal      = 1'b1;
        ext        = 1'b0;
        dec.pc     = in_pc;
        dec.rs     = in_ins[25:21];
        dec.rt     = in_ins[20:16];
        dec.wreg   = in_ins[20:16];
        dec.shamt  = in_ins[10:6];
        dec.jaddr  = in_ins[25:0];
        dec.imm    = {{(XLEN-16){in_ins[15]}}, in_ins[15:0]};
        dec.alu    = ALU_ADD;
        case (in_ins[31:26])
            OP_R: begin
                dec.wreg      = in_ins[15:11];
                dec.reg_write = 1'b1;
                case (in_ins[5:0])
                    6'b100100: dec.alu = ALU_AND;
                    6'b100101: dec.alu = ALU_OR;
                    6'b100000: dec.alu = ALU_ADD;
                    6'b100010: dec.alu = ALU_SUB;
                    6'b101010: dec.alu = ALU_SLT;
                    6'b100111: begin dec.alu = ALU_NOR; ext = 1'b1; end
                    6'b000000: begin dec.alu = ALU_SLL; ext = 1'b1; end
                    6'b000010: begin dec.alu = ALU_SRL; ext = 1'b1; end
                    default:   legal = 1'b0;
                endcase
            end
            OP_LW: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
            end
            OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.alu    = ALU_SUB;
            end
            OP_BNE: begin
                dec.branch    = 1'b1;
                dec.branch_ne = 1'b1;
                dec.alu       = ALU_SUB;
                ext           = 1'b1;
            end
            OP_J: dec.jump = 1'b1;
            OP_JAL: begin
                dec.jump      = 1'b1;
                dec.link      = 1'b1;
                dec.reg_write = 1'b1;
                dec.wreg      = 5'd31;
                ext           = 1'b1;
            end
            OP_ADDI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_SLTI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu       = ALU_SLT;
                ext           = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu         = (in_ins[26]) ? ALU_OR : ALU_AND;
                dec.imm         = '0;
                dec.imm[15:0]   = in_ins[15:0];
                ext             = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.imm         = '0;
                dec.imm[31:16]  = in_ins[15:0];
                ext             = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (ext && (EN_EXT == 0)) begin
            legal = 1'b0;
        end
        // Undecodable entries carry no side effects downstream, only the flag.
        if (!legal) begin
            dec.reg_write  = 1'b0;
            dec.mem_to_reg = 1'b0;
            dec.mem_write  = 1'b0;
            dec.alu_src    = 1'b0;
            dec.branch     = 1'b0;
            dec.branch_ne  = 1'b0;
            dec.jump       = 1'b0;
            dec.link       = 1'b0;
            dec.alu        = ALU_FALSE;
            dec.illegal    = 1'b1;
        end
    end

    assign out_valid = (state_q != S_EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid && in_ready_q && !flush;
    assign hs        = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        skid_d    = skid_q;
        ill_cnt_d = ill_cnt_q;
        // A delivery in the flush cycle still counts.
        if (hs && out_q.illegal && (ill_cnt_q != {CNT_W{1'b1}})) begin
            ill_cnt_d = ill_cnt_q + 1'b1;
        end
        if (flush) begin
            state_d = S_EMPTY;
            out_d   = '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        out_d   = dec;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (hs && accept) begin
                        out_d = dec;
                    end else if (hs) begin
                        out_d   = '0;
                        state_d = S_EMPTY;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (hs) begin
                        out_d   = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        in_ready_d = (state_d != S_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            ill_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            ill_cnt_q  <= ill_cnt_d;
        end
    end

    assign out_pc      = out_q.pc;
    assign out_rs      = out_q.rs;
    assign out_rt      = out_q.rt;
    assign out_wreg    = out_q.wreg;
    assign out_imm     = out_q.imm;
    assign out_shamt   = out_q.shamt;
    assign out_jaddr   = out_q.jaddr;
    assign RegWrite    = out_q.reg_write;
    assign MemtoReg    = out_q.mem_to_reg;
    assign MemWrite    = out_q.mem_write;
    assign ALUSrc      = out_q.alu_src;
    assign Branch      = out_q.branch;
    assign BranchNe    = out_q.branch_ne;
    assign Jump        = out_q.jump;
    assign Link        = out_q.link;
    assign alu_control = out_q.alu;
    assign illegal     = out_q.illegal;
    assign ill_cnt     = ill_cnt_q;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Bench for mips_decode_stage: an extended-set instance and a base-set instance (CNT_W=2)
// share one stimulus stream and are checked against a mnemonic-level reference model.
module tb_mips_decode_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [25:0] jaddr;
    logic        rw;
    logic        m2r;
    logic        mw;
    logic        alusrc;
    logic        br;
    logic        brne;
    logic        j;
    logic        link;
    logic [3:0]  alu;
    logic        ill;
  } ent_t;

  typedef enum {M_AND, M_OR, M_ADD, M_SUB, M_SLT, M_NOR, M_SLL, M_SRL, M_LW, M_SW, M_BEQ,
                M_BNE, M_J, M_JAL, M_ADDI, M_SLTI, M_ANDI, M_ORI, M_LUI, M_BAD} mn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_ins = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  logic a_in_ready, a_out_valid, a_rw, a_m2r, a_mw, a_alusrc, a_br, a_brne, a_j, a_link, a_ill;
  logic b_in_ready, b_out_valid, b_rw, b_m2r, b_mw, b_alusrc, b_br, b_brne, b_j, b_link, b_ill;
  logic [31:0] a_pc, a_imm, b_pc, b_imm;
  logic [4:0]  a_rs, a_rt, a_wreg, a_shamt, b_rs, b_rt, b_wreg, b_shamt;
  logic [25:0] a_jaddr, b_jaddr;
  logic [3:0]  a_alu, b_alu;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;
  ent_t        obs_a, obs_b;

  ent_t qa[$];
  ent_t qb[$];
  int   cnt_a = 0;
  int   cnt_b = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [5:0] ops [16] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                           6'h03, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h3F, 6'h11};
  logic [5:0] fns [10] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27, 6'h00, 6'h02,
                           6'h3F, 6'h01};

  always #5 clk = ~clk;

  mips_decode_stage #(.XLEN(32), .EN_EXT(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_rs(a_rs), .out_rt(a_rt), .out_wreg(a_wreg), .out_imm(a_imm),
    .out_shamt(a_shamt), .out_jaddr(a_jaddr), .RegWrite(a_rw), .MemtoReg(a_m2r),
    .MemWrite(a_mw), .ALUSrc(a_alusrc), .Branch(a_br), .BranchNe(a_brne), .Jump(a_j),
    .Link(a_link), .alu_control(a_alu), .illegal(a_ill), .ill_cnt(a_cnt));

  mips_decode_stage #(.XLEN(32), .EN_EXT(0), .CNT_W(2)) dut_base (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_rs(b_rs), .out_rt(b_rt), .out_wreg(b_wreg), .out_imm(b_imm),
    .out_shamt(b_shamt), .out_jaddr(b_jaddr), .RegWrite(b_rw), .MemtoReg(b_m2r),
    .MemWrite(b_mw), .ALUSrc(b_alusrc), .Branch(b_br), .BranchNe(b_brne), .Jump(b_j),
    .Link(b_link), .alu_control(b_alu), .illegal(b_ill), .ill_cnt(b_cnt));

  assign obs_a = {a_pc, a_rs, a_rt, a_wreg, a_shamt, a_imm, a_jaddr, a_rw, a_m2r, a_mw,
                  a_alusrc, a_br, a_brne, a_j, a_link, a_alu, a_ill};
  assign obs_b = {b_pc, b_rs, b_rt, b_wreg, b_shamt, b_imm, b_jaddr, b_rw, b_m2r, b_mw,
                  b_alusrc, b_br, b_brne, b_j, b_link, b_alu, b_ill};

  // Reference: name the instruction first, then derive every field from the mnemonic.
  function automatic ent_t decode_ref(input logic [31:0] ins, input logic [31:0] pc,
                                      input bit ext_en);
    ent_t e;
    mn_t  m;
    logic [5:0] op;
    op = ins[31:26];
    case (op)
      6'h00: case (ins[5:0])
               6'h24: m = M_AND;  6'h25: m = M_OR;  6'h20: m = M_ADD;  6'h22: m = M_SUB;
               6'h2A: m = M_SLT;  6'h27: m = M_NOR; 6'h00: m = M_SLL;  6'h02: m = M_SRL;
               default: m = M_BAD;
             endcase
      6'h23: m = M_LW;   6'h2B: m = M_SW;   6'h04: m = M_BEQ;  6'h05: m = M_BNE;
      6'h02: m = M_J;    6'h03: m = M_JAL;  6'h08: m = M_ADDI; 6'h0A: m = M_SLTI;
      6'h0C: m = M_ANDI; 6'h0D: m = M_ORI;  6'h0F: m = M_LUI;
      default: m = M_BAD;
    endcase
    if (!ext_en && (m inside {M_ANDI, M_ORI, M_SLTI, M_BNE, M_LUI, M_JAL, M_NOR, M_SLL, M_SRL}))
      m = M_BAD;
    e.pc    = pc;
    e.rs    = ins[25:21];
    e.rt    = ins[20:16];
    e.shamt = ins[10:6];
    e.jaddr = ins[25:0];
    e.wreg  = (op == 6'h00) ? ins[15:11] : (op == 6'h03) ? 5'd31 : ins[20:16];
    if (op == 6'h0C || op == 6'h0D) e.imm = {16'h0, ins[15:0]};
    else if (op == 6'h0F)           e.imm = {ins[15:0], 16'h0};
    else                            e.imm = 32'($signed(ins[15:0]));
    e.rw     = m inside {M_AND, M_OR, M_ADD, M_SUB, M_SLT, M_NOR, M_SLL, M_SRL, M_LW, M_ADDI,
                         M_SLTI, M_ANDI, M_ORI, M_LUI, M_JAL};
    e.m2r    = (m == M_LW);
    e.mw     = (m == M_SW);
    e.alusrc = m inside {M_LW, M_SW, M_ADDI, M_SLTI, M_ANDI, M_ORI, M_LUI};
    e.br     = m inside {M_BEQ, M_BNE};
    e.brne   = (m == M_BNE);
    e.j      = m inside {M_J, M_JAL};
    e.link   = (m == M_JAL);
    e.ill    = (m == M_BAD);
    case (m)
      M_AND, M_ANDI: e.alu = 4'b0000;
      M_OR, M_ORI:   e.alu = 4'b0001;
      M_SUB, M_BEQ, M_BNE: e.alu = 4'b0110;
      M_SLT, M_SLTI: e.alu = 4'b0111;
      M_NOR:         e.alu = 4'b1100;
      M_SLL:         e.alu = 4'b1000;
      M_SRL:         e.alu = 4'b1001;
      M_BAD:         e.alu = 4'b1111;
      default:       e.alu = 4'b0010;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 15)];
    if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 9)];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("a_out_valid", 128'(a_out_valid), 128'(qa.size() != 0));
    chk("a_in_ready", 128'(a_in_ready), 128'(qa.size() < 2));
    chk("a_ill_cnt", 128'(a_cnt), 128'(cnt_a));
    chk("b_out_valid", 128'(b_out_valid), 128'(qb.size() != 0));
    chk("b_in_ready", 128'(b_in_ready), 128'(qb.size() < 2));
    chk("b_ill_cnt", 128'(b_cnt), 128'(cnt_b));
    if (qa.size() != 0) chk("a_entry", 128'(obs_a), 128'(qa[0]));
    else chk("a_idle_ctrl", 128'({a_rw, a_m2r, a_mw, a_alusrc, a_br, a_brne, a_j, a_link}), 128'(0));
    if (qb.size() != 0) chk("b_entry", 128'(obs_b), 128'(qb[0]));
    else chk("b_idle_ctrl", 128'({b_rw, b_m2r, b_mw, b_alusrc, b_br, b_brne, b_j, b_link}), 128'(0));
  endtask

  // One clock: check what the last edge produced, drive, then advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic rdy);
    bit hs, acc;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    in_ins    = ins;
    in_pc     = pc_ctr;
    pc_ctr    = pc_ctr + 4;
    flush     = fl;
    out_ready = rdy;
    @(posedge clk);
    hs  = (qa.size() != 0) && rdy;
    acc = v && (qa.size() < 2) && !fl;
    if (hs && qa[0].ill) cnt_a = (cnt_a < 65535) ? cnt_a + 1 : cnt_a;
    if (hs && qb[0].ill) cnt_b = (cnt_b < 3) ? cnt_b + 1 : cnt_b;
    if (fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (hs) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (acc) begin
        qa.push_back(decode_ref(ins, in_pc, 1'b1));
        qb.push_back(decode_ref(ins, in_pc, 1'b0));
      end
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_a_valid", 128'(a_out_valid), 128'(0));
    chk("rst_a_entry", 128'(obs_a), 128'(0));
    chk("rst_a_cnt", 128'(a_cnt), 128'(0));
    chk("rst_b_valid", 128'(b_out_valid), 128'(0));
    chk("rst_b_entry", 128'(obs_b), 128'(0));
    chk("rst_b_cnt", 128'(b_cnt), 128'(0));
    qa.delete();
    qb.delete();
    cnt_a = 0;
    cnt_b = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    step(1'b1, 32'h0022_1820, 1'b0, 1'b1);
    #1;
    chk("add_valid", 128'(a_out_valid), 128'(1));
    chk("add_regwrite", 128'(a_rw), 128'(1));
    chk("add_alu", 128'(a_alu), 128'(4'b0010));
    chk("add_wreg", 128'(a_wreg), 128'(3));
    chk("add_illegal", 128'(a_ill), 128'(0));
    step(1'b1, 32'h3042_FFFF, 1'b0, 1'b1);
    #1;
    chk("andi_imm", 128'(a_imm), 128'(32'h0000_FFFF));
    chk("andi_alu", 128'(a_alu), 128'(4'b0000));
    chk("andi_alusrc", 128'(a_alusrc), 128'(1));
    step(1'b1, 32'h2042_FFFF, 1'b0, 1'b1);
    #1;
    chk("addi_imm", 128'(a_imm), 128'(32'hFFFF_FFFF));
    chk("addi_alu", 128'(a_alu), 128'(4'b0010));
    step(1'b1, 32'h0C00_0010, 1'b0, 1'b1);
    #1;
    chk("jal_ctrl", 128'({a_j, a_link, a_rw}), 128'(3'b111));
    chk("jal_wreg", 128'(a_wreg), 128'(31));
    chk("jal_jaddr", 128'(a_jaddr), 128'(26'h10));
    chk("jal_base_illegal", 128'(b_ill), 128'(1));
    chk("jal_base_we", 128'({b_rw, b_mw, b_j, b_link}), 128'(0));
    chk("jal_base_alu", 128'(b_alu), 128'(4'b1111));
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Four-instruction burst against a 3-cycle downstream stall.
    step(1'b1, 32'h0022_1820, 1'b0, 1'b0);
    step(1'b1, 32'h8C43_0004, 1'b0, 1'b0);
    #1 chk("stall_in_ready", 128'(a_in_ready), 128'(0));
    step(1'b1, 32'hAC43_0008, 1'b0, 1'b0);
    step(1'b1, 32'hAC43_0008, 1'b0, 1'b1);
    step(1'b1, 32'hAC43_0008, 1'b0, 1'b1);
    step(1'b1, 32'h1443_FFFE, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Flush a full stage while a new instruction is offered.
    step(1'b1, 32'h2001_0001, 1'b0, 1'b0);
    step(1'b1, 32'h2002_0002, 1'b0, 1'b0);
    step(1'b1, 32'h2003_0003, 1'b1, 1'b0);
    #1;
    chk("flush_valid", 128'(a_out_valid), 128'(0));
    chk("flush_in_ready", 128'(a_in_ready), 128'(1));
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Reset while entries are held.
    step(1'b1, 32'h3C01_1234, 1'b0, 1'b0);
    step(1'b1, 32'h0001_1080, 1'b0, 1'b0);
    do_reset();

    // Illegal counter saturation on the 2-bit instance.
    step(1'b1, 32'hFC00_0000, 1'b0, 1'b1);
    step(1'b1, 32'hFC00_0000, 1'b0, 1'b1);
    #1 chk("ill_cnt_1", 128'(b_cnt), 128'(1));
    step(1'b1, 32'hFC00_0000, 1'b0, 1'b1);
    #1 chk("ill_cnt_2", 128'(b_cnt), 128'(2));
    step(1'b1, 32'hFC00_0000, 1'b0, 1'b1);
    #1 chk("ill_cnt_3", 128'(b_cnt), 128'(3));
    step(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("ill_cnt_sat", 128'(b_cnt), 128'(3));
    chk("ill_cnt_wide", 128'(a_cnt), 128'(4));

    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_ins(), $urandom_range(0, 31) == 0,
           $urandom_range(0, 3) != 0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
